// File: rtl/audio_meter_pkg.sv
// Shared definitions for the audio metering path (int_norm and level meter).
package audio_meter_pkg;

  // Native magnitude width produced by int_norm.
  localparam int unsigned WS = 16;

  // Default clipping threshold: magnitudes at or above this count as clipped.
  localparam logic [WS-1:0] CLIP_THR_DEF = 16'hFF00;

  // Unsigned maximum of two native-width magnitudes.
  function automatic logic [WS-1:0] umax(input logic [WS-1:0] a,
                                         input logic [WS-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/audio_level_meter_peak_hold_decay.sv
// Peak-hold register: tracks the largest window level, holds it for HOLD
// windows, then decays geometrically (with a minimum step of 1) toward the
// current level.
module peak_hold_decay #(
  parameter int unsigned WS          = 16,
  parameter int unsigned HOLD        = 32,
  parameter int unsigned DECAY_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          upd,
  input  logic [WS-1:0] L,
  output logic [WS-1:0] peak
);

  localparam int unsigned HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic [WS-1:0] step;
  logic [WS-1:0] step_min1;
  logic [WS-1:0] decayed;
  logic [WS-1:0] decay_next;

  // Decay candidate; only used when L < peak, so peak >= 1 and the
  // subtraction cannot underflow.
  always_comb begin
    step       = peak >> DECAY_SHIFT;
    step_min1  = (step == '0) ? {{(WS-1){1'b0}}, 1'b1} : step;
    decayed    = peak - step_min1;
    decay_next = (L > decayed) ? L : decayed;
  end

  // Peak and hold counter update, once per completed window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak     <= '0;
      hold_cnt <= '0;
    end else if (clr) begin
      peak     <= '0;
      hold_cnt <= '0;
    end else if (upd) begin
      if (L >= peak) begin
        peak     <= L;
        hold_cnt <= HW'(HOLD);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end else begin
        peak <= decay_next;
      end
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Windowed audio level meter: reports the maximum magnitude and a sticky
// clip flag per window of 2^WIN_LOG2 accepted samples, plus a peak-hold
// value with hold and decay, and bar-height slices of both.
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int unsigned    WS          = 16,
  parameter int unsigned    WIN_LOG2    = 8,
  parameter int unsigned    HOLD        = 32,
  parameter int unsigned    DECAY_SHIFT = 4,
  parameter int unsigned    BAR_W       = 5,
  parameter logic [WS-1:0]  CLIP_THR    = CLIP_THR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WS-1:0]    in_mag,
  input  logic             clr,
  output logic             out_valid,
  output logic [WS-1:0]    level,
  output logic [WS-1:0]    peak,
  output logic [BAR_W-1:0] bar,
  output logic [BAR_W-1:0] peak_bar,
  output logic             clip
);

  localparam logic [WIN_LOG2-1:0] WLAST = '1;

  logic [WIN_LOG2-1:0] wcnt;
  logic [WS-1:0]       wmax;
  logic                wclip;
  logic                accept;
  logic                hit;
  logic                wend;
  logic [WS-1:0]       lnext;

  // Per-sample decode: a sample under clr is discarded; the window-end
  // level includes the closing sample itself.
  always_comb begin
    accept = in_valid & ~clr;
    hit    = (in_mag >= CLIP_THR);
    wend   = accept && (wcnt == WLAST);
    lnext  = (in_mag > wmax) ? in_mag : wmax;
  end

  // Window accumulation, window-end capture and the output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      wmax      <= '0;
      wclip     <= 1'b0;
      level     <= '0;
      clip      <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      wcnt      <= '0;
      wmax      <= '0;
      wclip     <= 1'b0;
      level     <= '0;
      clip      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= wend;
      if (in_valid) begin
        wcnt <= wcnt + 1'b1;
        if (wend) begin
          level <= lnext;
          clip  <= wclip | hit;
          wmax  <= '0;
          wclip <= 1'b0;
        end else begin
          wmax  <= lnext;
          wclip <= wclip | hit;
        end
      end
    end
  end

  peak_hold_decay #(
    .WS          (WS),
    .HOLD        (HOLD),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_peak (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .upd   (wend),
    .L     (lnext),
    .peak  (peak)
  );

  assign bar      = level[WS-1 -: BAR_W];
  assign peak_bar = peak[WS-1 -: BAR_W];

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: table of 4-sample windows with expected
// level/peak/clip, checked through a scoreboard queue, plus clr and
// asynchronous-reset sequences.
module tb_audio_level_meter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_mag;
  logic        clr;
  logic        out_valid;
  logic [15:0] level;
  logic [15:0] peak;
  logic [4:0]  bar;
  logic [4:0]  peak_bar;
  logic        clip;

  audio_level_meter #(
    .WS          (16),
    .WIN_LOG2    (2),
    .HOLD        (2),
    .DECAY_SHIFT (2),
    .BAR_W       (5),
    .CLIP_THR    (16'hFF00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_mag    (in_mag),
    .clr       (clr),
    .out_valid (out_valid),
    .level     (level),
    .peak      (peak),
    .bar       (bar),
    .peak_bar  (peak_bar),
    .clip      (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lvl;
    logic [15:0] pk;
    logic        clp;
  } exp_t;

  typedef struct {
    logic [15:0] s [4];
    int unsigned gap;
    exp_t        e;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  exp_t q [$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   npush = 0;
  int   nout  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  task automatic setv(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d, input int unsigned g,
                      input logic [15:0] l, input logic [15:0] p, input logic cl);
    tbl[i].s[0] = a; tbl[i].s[1] = b; tbl[i].s[2] = c; tbl[i].s[3] = d;
    tbl[i].gap = g;
    tbl[i].e.lvl = l; tbl[i].e.pk = p; tbl[i].e.clp = cl;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic send(input logic [15:0] m, input bit last, input exp_t e);
    in_valid = 1'b1;
    in_mag   = m;
    if (last) begin
      q.push_back(e);
      npush++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mag   = '0;
  endtask

  task automatic run_vec(input int i);
    for (int k = 0; k < 4; k++) begin
      repeat (tbl[i].gap) begin @(posedge clk); #1; end
      send(tbl[i].s[k], k == 3, tbl[i].e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_peak"}, peak, 0);
    chk({tag, "_clip"}, clip, 0);
    chk({tag, "_bar"}, bar, 0);
    chk({tag, "_peak_bar"}, peak_bar, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest queued window.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (level=%0d) at %0t", level, $time);
      end else begin
        mon_e = q.pop_front();
        nout++;
        chk("level", level, mon_e.lvl);
        chk("peak", peak, mon_e.pk);
        chk("clip", clip, mon_e.clp);
        chk("bar", bar, mon_e.lvl[15:11]);
        chk("peak_bar", peak_bar, mon_e.pk[15:11]);
      end
    end
  end

  exp_t none;

  initial begin
    none = '{lvl: 16'd0, pk: 16'd0, clp: 1'b0};

    // Phase A: first window, hold then decay, clip window, clip boundary.
    setv(0,  16'd100, 16'd900, 16'd300, 16'd50,  0, 16'd900,   16'd900,   1'b0);
    setv(1,  16'd400, 16'd10,  16'd0,   16'd399, 0, 16'd400,   16'd900,   1'b0);
    setv(2,  16'd0,   16'd400, 16'd1,   16'd2,   3, 16'd400,   16'd900,   1'b0);
    setv(3,  16'd400, 16'd400, 16'd400, 16'd400, 0, 16'd400,   16'd675,   1'b0);
    setv(4,  16'd399, 16'd0,   16'd400, 16'd7,   1, 16'd400,   16'd507,   1'b0);
    setv(5,  16'd5,   16'hFF00,16'd7,   16'd8,   0, 16'hFF00,  16'hFF00,  1'b1);
    setv(6,  16'd0,   16'd0,   16'd0,   16'd0,   0, 16'd0,     16'hFF00,  1'b0);
    setv(7,  16'hFEFF,16'd0,   16'd0,   16'd0,   0, 16'hFEFF,  16'hFF00,  1'b0);
    // Phase B (after clr): minimum decay step, then clip on the closing sample.
    setv(8,  16'd3,   16'd1,   16'd2,   16'd0,   0, 16'd3,     16'd3,     1'b0);
    setv(9,  16'd0,   16'd0,   16'd0,   16'd0,   0, 16'd0,     16'd3,     1'b0);
    setv(10, 16'd0,   16'd0,   16'd0,   16'd0,   2, 16'd0,     16'd3,     1'b0);
    setv(11, 16'd0,   16'd0,   16'd0,   16'd0,   0, 16'd0,     16'd2,     1'b0);
    setv(12, 16'd0,   16'd0,   16'd0,   16'd0,   0, 16'd0,     16'd1,     1'b0);
    setv(13, 16'd0,   16'd0,   16'd0,   16'd0,   0, 16'd0,     16'd0,     1'b0);
    setv(14, 16'd0,   16'd0,   16'd0,   16'hFFFF,0, 16'hFFFF,  16'hFFFF,  1'b1);
    // Phase C (after async reset).
    setv(15, 16'd10,  16'd20,  16'd30,  16'd40,  0, 16'd40,    16'd40,    1'b0);

    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_mag   = '0;
    clr      = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // clr with a sample after two samples of a window.
    send(16'd500, 1'b0, none);
    send(16'd600, 1'b0, none);
    in_valid = 1'b1;
    in_mag   = 16'hFFFF;
    clr      = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_mag   = '0;
    @(negedge clk);
    chk_zero("clr");
    @(posedge clk); #1;

    for (int i = 8; i < 15; i++) run_vec(i);

    // Asynchronous reset between edges, mid-window.
    send(16'd1, 1'b0, none);
    send(16'd2, 1'b0, none);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(15);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    chk("out_count", nout, npush);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_level_meter.md
AUDIO_LEVEL_METER -- requirements
Module: audio_level_meter

Interface
REQ-001 Parameter WS, default 16: sample magnitude width in bits.
REQ-002 Parameter WIN_LOG2, default 8: window length is 2^WIN_LOG2 accepted samples.
REQ-003 Parameter HOLD, default 32: number of windows the peak is held before decay starts.
REQ-004 Parameter DECAY_SHIFT, default 4: per-window peak decay is peak >> DECAY_SHIFT.
REQ-005 Parameter BAR_W, default 5: width of the bar-height outputs.
REQ-006 Parameter CLIP_THR, default 16'hFF00: magnitude at or above this value counts as clipping.
REQ-007 clk  in  1  single system clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 in_valid  in  1  in_mag carries a sample this cycle; always accepted, no backpressure.
REQ-010 in_mag  in  WS  unsigned magnitude from the upstream int_norm stage.
REQ-011 clr  in  1  synchronous clear of all measurement state.
REQ-012 out_valid  out  1  one-cycle pulse; level, peak, bar, peak_bar and clip are updated.
REQ-013 level  out  WS  maximum magnitude of the last completed window.
REQ-014 peak  out  WS  peak-hold value with hold and decay.
REQ-015 bar  out  BAR_W  level[WS-1 -: BAR_W].
REQ-016 peak_bar  out  BAR_W  peak[WS-1 -: BAR_W].
REQ-017 clip  out  1  some sample in the last completed window was >= CLIP_THR.

Function
REQ-018 Window counter wcnt (WIN_LOG2 bits) increments on each in_valid and wraps from 2^WIN_LOG2-1 to 0.
REQ-019 Running maximum wmax updates on each in_valid: wmax <= max(wmax, in_mag); the sticky flag wclip is set when in_mag >= CLIP_THR.
REQ-020 Window end = in_valid while wcnt == 2^WIN_LOG2-1; on that edge level <= max(wmax, in_mag), clip <= wclip | (in_mag >= CLIP_THR), wmax <= 0, wclip <= 0.
REQ-021 out_valid is high exactly in the cycle after the window-end edge, i.e. latency is 1 cycle from the last accepted sample; it is low otherwise.
REQ-022 Peak update at window end uses the new level L: if L >= peak, then peak <= L and hold_cnt <= HOLD.
REQ-023 Otherwise, if hold_cnt != 0, then hold_cnt decrements and peak is unchanged.
REQ-024 Otherwise, peak <= max(L, peak - max(peak >> DECAY_SHIFT, 1)), so decay always makes progress and never falls below L.
REQ-025 bar and peak_bar are combinational slices of the registered level and peak; they change only with them.
REQ-026 Gaps between in_valid are allowed with no time limit; window state is retained across gaps.
REQ-027 clr zeros wcnt, wmax, wclip, level, peak, hold_cnt and clip, and holds out_valid low in the following cycle.
REQ-028 A sample presented while clr is high is discarded.
REQ-029 All arithmetic is unsigned WS-bit with no overflow path; decay subtraction cannot underflow.

Reset
REQ-030 While rst_n is low, all registers are 0: wcnt, wmax, wclip, level, peak, hold_cnt, clip, out_valid.
REQ-031 Reset assertion mid-window discards the partial window; the first window after release starts at wcnt = 0.
REQ-032 Reset release is used synchronously by upstream logic; the block makes no reset-release guarantee beyond REQ-030.

Structure
REQ-033 A shared package audio_meter_pkg holds WS, default CLIP_THR and a max helper function; it is shared with int_norm users.
REQ-034 The peak hold/decay logic (REQ-022 to REQ-024) is one sub-module, peak_hold_decay, with inputs clk, rst_n, clr, upd, L and output peak.
REQ-035 The remaining window, clip and output logic is in audio_level_meter itself.

Verification (bench parameters: WIN_LOG2=2, HOLD=2, DECAY_SHIFT=2, BAR_W=5, WS=16)
REQ-036 Samples 100, 900, 300, 50 on consecutive cycles -> one cycle after the 4th: out_valid=1, level=900, peak=900, clip=0.
REQ-037 Then four windows with level 400 -> peak stays 900 for 2 windows, then 675, then 507.
REQ-038 A window containing 16'hFF00 -> clip=1, bar=31; the next window of all zeros -> clip=0, level=0.
REQ-039 Peak at 3 and levels 0 after hold expires -> peak 2, 1, 0 (minimum step of 1).
REQ-040 clr asserted with in_valid after 2 samples of a window -> all outputs 0; the next 4 samples form a complete window.
REQ-041 rst_n pulsed low mid-window, asynchronously between clock edges -> outputs 0 immediately; the first out_valid comes after 4 new samples.
